// File: rtl/conv_processor_result_reader.sv
// Result memory read-out engine: fetches count words from base_addr and streams them through a 2-entry FIFO.
// Optional build macro CONV_READER_SATURATE_EN selects signed saturation instead of truncation.
module conv_processor_result_reader #(
  parameter int DATA_WIDTH = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          base_q, base_d;
  logic [ADDR_WIDTH:0]            count_q, count_d;
  logic [ADDR_WIDTH:0]            issued_q, issued_d;
  logic [ADDR_WIDTH:0]            popped_q, popped_d;
  logic                           inflight_q, inflight_d;
  logic [1:0][OUT_WIDTH-1:0]      fdata_q, fdata_d;
  logic [1:0]                     flast_q, flast_d;
  logic                           rd_ptr_q, rd_ptr_d;
  logic                           wr_ptr_q, wr_ptr_d;
  logic [1:0]                     occ_q, occ_d;

  logic                           pop_s;
  logic                           rd_en_s;
  logic [1:0]                     pending_s;
  logic [ADDR_WIDTH:0]            ret_idx_s;

  function automatic logic [OUT_WIDTH-1:0] conv_word(input logic [DATA_WIDTH-1:0] w);
`ifdef CONV_READER_SATURATE_EN
    logic signed [DATA_WIDTH-1:0] v;
    logic signed [DATA_WIDTH-1:0] hi;
    logic signed [DATA_WIDTH-1:0] lo;
    v  = $signed(w);
    hi = $signed({{(DATA_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
    lo = ~hi;
    if (v > hi) begin
      conv_word = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (v < lo) begin
      conv_word = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      conv_word = w[OUT_WIDTH-1:0];
    end
`else
    conv_word = w[OUT_WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    inflight_d = 1'b0;
    fdata_d    = fdata_q;
    flast_d    = flast_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    pop_s     = (occ_q != 2'd0) && out_ready;
    // The word returning now was issued last cycle, so its index is one behind issued_q.
    ret_idx_s = issued_q - (ADDR_WIDTH+1)'(1);
    pending_s = occ_q + {1'b0, inflight_q} - {1'b0, pop_s};
    rd_en_s   = (state_q == RUN) && !clear && (issued_q < count_q) && (pending_s < 2'd2);

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          count_d  = count;
          issued_d = '0;
          popped_d = '0;
          state_d  = (count == '0) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (pop_s && flast_q[rd_ptr_q]) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rd_en_s) begin
      issued_d   = issued_q + (ADDR_WIDTH+1)'(1);
      inflight_d = 1'b1;
    end else begin
      inflight_d = 1'b0;
    end

    if (inflight_q) begin
      fdata_d[wr_ptr_q] = conv_word(mem_rdata);
      flast_d[wr_ptr_q] = (ret_idx_s == count_q - (ADDR_WIDTH+1)'(1));
      wr_ptr_d          = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
      popped_d = popped_q + (ADDR_WIDTH+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop_s};

    // Abort drops buffered words and any read still in flight.
    if (clear) begin
      state_d    = IDLE;
      inflight_d = 1'b0;
      occ_d      = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      issued_d   = '0;
      popped_d   = '0;
    end else begin
      occ_d = occ_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      fdata_q    <= '0;
      flast_q    <= 2'b00;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
      fdata_q    <= fdata_d;
      flast_q    <= flast_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
    end
  end

  assign mem_rd_en = rd_en_s;
  assign mem_addr  = (state_q == RUN) ? (base_q + issued_q[ADDR_WIDTH-1:0]) : '0;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = out_valid ? fdata_q[rd_ptr_q] : '0;
  assign out_last  = out_valid & flast_q[rd_ptr_q];
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule
